// File: rtl/wb_pkg.sv
// wb_pkg: shared result/load encodings and MEM/WB register layout for the write-back stage
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_LINK = 2'b10
  } result_sel_t;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } load_type_t;

  // Fields captured from MEM; select is kept raw so the unused 2'b11 code is representable
  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  result_sel;
    logic [31:0] alu_result;
    logic [31:0] load_word;
    logic [31:0] pc_plus4;
  } wb_fields_t;

endpackage

// File: rtl/ctrl_bus_if.sv
// ctrl_bus_if: clock and asynchronous active-high reset bundle
interface ctrl_bus_if;
  logic clk;
  logic reset;
  modport central (input clk, input reset);
endinterface

// File: rtl/wb_load_ext.sv
// wb_load_ext: little-endian sub-word extraction with sign/zero extension for loads
import wb_pkg::*;

module wb_load_ext (
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // Halfword lane ignores offset[0]; anything not a sub-word load passes the word through
  always_comb begin
    byte_v = word_i[8*offset_i +: 8];
    half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = load_type_i == LD_LB  ? {{24{byte_v[7]}}, byte_v} :
             load_type_i == LD_LBU ? {24'h0, byte_v} :
             load_type_i == LD_LH  ? {{16{half_v[15]}}, half_v} :
             load_type_i == LD_LHU ? {16'h0, half_v} : word_i;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, result select, regfile write/forward port, retire counter (optional WB_LOAD_EXT_EN)
import wb_pkg::*;

module wb_stage #(
  parameter int CNT_W = 32
) (
  ctrl_bus_if.central ctrl_bus,
  input  logic             m_valid,
  input  logic             m_reg_write,
  input  logic [4:0]       m_rd,
  input  logic [1:0]       m_result_sel,
  input  logic [2:0]       m_load_type,
  input  logic [31:0]      m_alu_result,
  input  logic [31:0]      m_load_word,
  input  logic [31:0]      m_pc_plus4,
  input  logic             stall,
  input  logic             flush,
  output logic             reg_write,
  output logic [4:0]       rd,
  output logic [31:0]      reg_in,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [31:0]      fwd_data,
  output logic [CNT_W-1:0] instret
);
  wb_fields_t       fields_d, fields_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] instret_d, instret_q;
  logic [31:0]      load_data;

  // Next state: stall holds everything, flush squashes validity even under stall,
  // and an instruction retires when it leaves an unstalled WB
  always_comb begin
    fields_d  = stall ? fields_q : '{m_reg_write, m_rd, m_result_sel,
                                     m_alu_result, m_load_word, m_pc_plus4};
    valid_d   = flush ? 1'b0 : (stall ? valid_q : m_valid);
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, valid_q & ~stall};
  end

  // MEM/WB register and retire counter
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
    if (ctrl_bus.reset) begin
      fields_q  <= '0;
      valid_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      fields_q  <= fields_d;
      valid_q   <= valid_d;
      instret_q <= instret_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] load_type_d, load_type_q;

  // Load type only exists in the register when extraction is built in
  always_comb load_type_d = stall ? load_type_q : m_load_type;

  // Load type register shares the MEM/WB reset and hold behaviour
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
    if (ctrl_bus.reset) load_type_q <= LD_LW;
    else                load_type_q <= load_type_d;
  end

  wb_load_ext u_load_ext (
    .load_type_i (load_type_q),
    .offset_i    (fields_q.alu_result[1:0]),
    .word_i      (fields_q.load_word),
    .data_o      (load_data)
  );
`else
  logic unused_load_type;
  assign unused_load_type = ^m_load_type;
  assign load_data        = fields_q.load_word;
`endif

  // Write port is combinational from the register so the regfile can capture on the same cycle;
  // writes to $0 are suppressed and the reserved select code falls back to the ALU result
  always_comb begin
    reg_write = valid_q & fields_q.reg_write & (fields_q.rd != 5'd0);
    rd        = fields_q.rd;
    reg_in    = fields_q.result_sel == RES_LOAD ? load_data :
                fields_q.result_sel == RES_LINK ? fields_q.pc_plus4 : fields_q.alu_result;
    fwd_valid = reg_write;
    fwd_rd    = fields_q.rd;
    fwd_data  = reg_in;
    instret   = instret_q;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage (expects WB_LOAD_EXT_EN to match the RTL build)
import wb_pkg::*;

module tb_wb_stage;
  ctrl_bus_if bus ();

  logic        m_valid, m_reg_write, stall, flush;
  logic [4:0]  m_rd;
  logic [1:0]  m_result_sel;
  logic [2:0]  m_load_type;
  logic [31:0] m_alu_result, m_load_word, m_pc_plus4;
  logic        reg_write, fwd_valid, reg_write_s, fwd_valid_s;
  logic [4:0]  rd, fwd_rd, rd_s, fwd_rd_s;
  logic [31:0] reg_in, fwd_data, reg_in_s, fwd_data_s, instret;
  logic [3:0]  instret_s;

  int errors = 0;
  int checks = 0;

  wb_stage u_dut (
    .ctrl_bus(bus.central), .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
    .m_result_sel(m_result_sel), .m_load_type(m_load_type), .m_alu_result(m_alu_result),
    .m_load_word(m_load_word), .m_pc_plus4(m_pc_plus4), .stall(stall), .flush(flush),
    .reg_write(reg_write), .rd(rd), .reg_in(reg_in), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  wb_stage #(.CNT_W(4)) u_small (
    .ctrl_bus(bus.central), .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
    .m_result_sel(m_result_sel), .m_load_type(m_load_type), .m_alu_result(m_alu_result),
    .m_load_word(m_load_word), .m_pc_plus4(m_pc_plus4), .stall(stall), .flush(flush),
    .reg_write(reg_write_s), .rd(rd_s), .reg_in(reg_in_s), .fwd_valid(fwd_valid_s),
    .fwd_rd(fwd_rd_s), .fwd_data(fwd_data_s), .instret(instret_s)
  );

  always #5 bus.clk = ~bus.clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] d, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] lw,
                       input logic [31:0] pc4);
    m_valid = v; m_reg_write = rw; m_rd = d; m_result_sel = sel; m_load_type = lt;
    m_alu_result = alu; m_load_word = lw; m_pc_plus4 = pc4;
  endtask

  task automatic step();
    @(posedge bus.clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, RES_ALU, LD_LW, 32'h0, 32'h0, 32'h0);
  endtask

  logic [2:0]  ld_type [4] = '{LD_LB, LD_LBU, LD_LH, LD_LHU};
  logic [1:0]  ld_off  [4] = '{2'd3, 2'd3, 2'd2, 2'd1};
`ifdef WB_LOAD_EXT_EN
  logic [31:0] ld_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
`else
  logic [31:0] ld_exp  [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.clk = 1'b0;
    bus.reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    #2;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_rd", rd, 0);
    chk("rst_reg_in", reg_in, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_rd", fwd_rd, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_instret", instret, 0);
    step();
    bus.reset = 1'b0;
    chk("post_rst_reg_write", reg_write, 0);

    drive(1'b1, 1'b1, 5'd5, RES_ALU, LD_LW, 32'h0000_1234, 32'h0, 32'h0);
    step();
    chk("alu_reg_write", reg_write, 1);
    chk("alu_rd", rd, 5);
    chk("alu_reg_in", reg_in, 32'h0000_1234);
    chk("alu_fwd_valid", fwd_valid, 1);
    chk("alu_fwd_rd", fwd_rd, 5);
    chk("alu_fwd_data", fwd_data, 32'h0000_1234);
    chk("alu_instret_before", instret, 0);
    idle();
    step();
    chk("alu_instret_after", instret, 1);
    chk("alu_idle_reg_write", reg_write, 0);

    drive(1'b1, 1'b1, 5'd0, RES_ALU, LD_LW, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step();
    chk("r0_reg_write", reg_write, 0);
    chk("r0_fwd_valid", fwd_valid, 0);
    chk("r0_reg_in", reg_in, 32'hFFFF_FFFF);
    idle();
    step();
    chk("r0_instret", instret, 2);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'd7, RES_LOAD, ld_type[i], {30'h400, ld_off[i]}, 32'h80FF_7F01, 32'h0);
      step();
      chk($sformatf("load%0d_reg_in", i), reg_in, ld_exp[i]);
      chk($sformatf("load%0d_reg_write", i), reg_write, 1);
    end
    idle();
    step();
    chk("load_instret", instret, 6);

    drive(1'b1, 1'b1, 5'd31, RES_LINK, LD_LW, 32'hDEAD_BEEF, 32'h0, 32'h0040_0008);
    step();
    chk("link_reg_in", reg_in, 32'h0040_0008);
    chk("link_rd", rd, 31);
    chk("link_reg_write", reg_write, 1);
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd3, RES_ALU, LD_LW, 32'h0000_0055, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_reg_in", i), reg_in, 32'h0040_0008);
      chk($sformatf("stall%0d_rd", i), rd, 31);
      chk($sformatf("stall%0d_reg_write", i), reg_write, 1);
      chk($sformatf("stall%0d_instret", i), instret, 6);
    end
    stall = 1'b0;
    idle();
    step();
    chk("link_instret", instret, 7);
    chk("link_done_reg_write", reg_write, 0);

    drive(1'b1, 1'b1, 5'd9, RES_ALU, LD_LW, 32'h0000_0099, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    chk("flush_reg_write", reg_write, 0);
    chk("flush_fwd_valid", fwd_valid, 0);
    flush = 1'b0;
    idle();
    step();
    chk("flush_instret", instret, 7);

    drive(1'b1, 1'b1, 5'd10, RES_ALU, LD_LW, 32'h0000_00AA, 32'h0, 32'h0);
    step();
    chk("pre_flush_stall_reg_write", reg_write, 1);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("flush_stall_reg_write", reg_write, 0);
    chk("flush_stall_instret", instret, 7);
    stall = 1'b0;
    flush = 1'b0;
    idle();
    step();
    chk("flush_stall_after_instret", instret, 7);

    drive(1'b1, 1'b1, 5'd12, RES_ALU, LD_LW, 32'h00C0_FFEE, 32'h0, 32'h0);
    step();
    chk("pre_reset_reg_write", reg_write, 1);
    idle();
    #2;
    bus.reset = 1'b1;
    #1;
    chk("async_rst_reg_write", reg_write, 0);
    chk("async_rst_rd", rd, 0);
    chk("async_rst_reg_in", reg_in, 0);
    chk("async_rst_instret", instret, 0);
    chk("async_rst_small_instret", instret_s, 0);
    bus.reset = 1'b0;

    drive(1'b1, 1'b1, 5'd1, RES_ALU, LD_LW, 32'h0000_0001, 32'h0, 32'h0);
    repeat (15) step();
    idle();
    step();
    chk("wrap_small_max", instret_s, 15);
    chk("wrap_big_15", instret, 15);
    drive(1'b1, 1'b1, 5'd1, RES_ALU, LD_LW, 32'h0000_0001, 32'h0, 32'h0);
    step();
    idle();
    step();
    chk("wrap_small_zero", instret_s, 0);
    chk("wrap_big_16", instret, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port ctrl_bus  ctrl_bus_if.central  --  carries ctrl_bus.clk (single clock) and ctrl_bus.reset (asynchronous, active-high); listed first.
REQ-003 SHALL have m_valid  input  1  MEM stage holds a valid instruction.
REQ-004 SHALL have m_reg_write  input  1  instruction writes a register.
REQ-005 SHALL have m_rd  input  5  destination register.
REQ-006 SHALL have m_result_sel  input  2  result_sel_t (ALU, LOAD, LINK).
REQ-007 SHALL have m_load_type  input  3  load_type_t (LW, LB, LBU, LH, LHU).
REQ-008 SHALL have m_alu_result, m_load_word, m_pc_plus4  input  32 each  candidate results.
REQ-009 SHALL have stall  input  1  hold the MEM/WB register; flush  input  1  squash the incoming instruction.
REQ-010 SHALL have reg_write  output  1; rd  output  5; reg_in  output  32  -- regfile write port.
REQ-011 SHALL have fwd_valid  output  1; fwd_rd  output  5; fwd_data  output  32  -- forwarding source for the hazard unit.
REQ-012 SHALL have instret  output  CNT_W  retired-instruction count.

Function
REQ-013 SHALL capture all m_* fields into the MEM/WB register on posedge ctrl_bus.clk when stall=0; SHALL hold every field when stall=1.
REQ-014 SHALL load valid_q <= m_valid & ~flush when stall=0; flush=1 SHALL clear valid_q even when stall=1 (flush wins).
REQ-015 SHALL drive reg_write = valid_q & reg_write_q & (rd_q != 0); writes to $0 are never issued.
REQ-016 SHALL drive rd = rd_q and reg_in = selected result, combinationally from the register (regfile captures on the following negedge, same cycle).
REQ-017 SHALL select ALU -> alu_result_q, LOAD -> extracted load data, LINK -> pc_plus4_q; encoding 2'b11 SHALL select alu_result_q.
REQ-018 SHALL, for loads, use byte offset alu_result_q[1:0], little-endian lanes: byte lane = offset, halfword lane = offset[1] (offset[0] ignored).
REQ-019 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; LW and undefined encodings SHALL pass load_word_q unmodified.
REQ-020 SHALL drive fwd_valid = reg_write, fwd_rd = rd_q, fwd_data = reg_in.
REQ-021 SHALL increment instret by 1 on each posedge where valid_q=1 and stall=0 (instruction leaves WB); stalled cycles SHALL NOT count; wraps 2^CNT_W-1 -> 0.
REQ-022 SHALL reissue the identical write each stalled cycle (idempotent re-write is permitted).
REQ-023 SHALL NOT stall upstream; zero-bubble throughput of one instruction per cycle.

Reset
REQ-024 SHALL, on ctrl_bus.reset asserted (asynchronous, any time incl. mid-stall), clear valid_q, all captured fields and instret to 0.
REQ-025 SHALL present reg_write=0, rd=0, reg_in=0, fwd_valid=0, fwd_rd=0, fwd_data=0, instret=0 while reset is asserted and until the first capture.

Configuration
REQ-026 SHALL honour macro WB_LOAD_EXT_EN: defined -> sub-word extraction per REQ-018/019; undefined -> LOAD selects load_word_q unmodified, m_load_type ignored and not registered.

Structure
REQ-027 SHALL place result_sel_t, load_type_t and their encodings in shared package wb_pkg.
REQ-028 SHALL implement extraction in sub-module wb_load_ext (combinational: load_type, offset, word -> data), instantiated only under WB_LOAD_EXT_EN.

Verification
REQ-029 ALU op rd=5, alu=0x0000_1234 -> next cycle reg_write=1, rd=5, reg_in=0x0000_1234, instret=1 after following edge.
REQ-030 Write to rd=0, alu=0xFFFF_FFFF -> reg_write=0, fwd_valid=0; instret still increments.
REQ-031 LB word=0x80FF_7F01, offset 3 -> reg_in=0xFFFF_FF80; LBU offset 3 -> 0x0000_0080; LH offset 2 -> 0xFFFF_80FF; LHU offset 1 -> 0x0000_7F01 (macro off: all -> 0x80FF_7F01).
REQ-032 LINK pc_plus4=0x0040_0008, rd=31, then stall 3 cycles -> reg_in held at 0x0040_0008 for 4 cycles, instret +1 only.
REQ-033 flush=1 with m_valid=1 (also with stall=1) -> valid_q=0, reg_write=0 next cycle, instret unchanged.
REQ-034 Reset asserted between clock edges while valid_q=1 -> reg_write, rd, reg_in, instret drop to 0 immediately; instret=0xFFFF_FFFF then one retire -> 0.
